// File: rtl/trig_window_integrator.sv
// Trigger-gated charge integrator: per accepted trigger, averages a pedestal,
// skips a programmable delay, then integrates baseline-subtracted samples.
module trig_window_integrator #(
    parameter int LOG2_BL = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               trig,
    input  logic signed [15:0] din,
    input  logic        [7:0]  delay,
    input  logic        [7:0]  win_len,
    output logic signed [23:0] integ_out,
    output logic signed [15:0] baseline_out,
    output logic               out_valid,
    output logic               oflow,
    output logic               busy
);

    localparam int         BL      = 1 << LOG2_BL;
    localparam logic [7:0] BL_LAST = 8'(BL - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BASE  = 3'd1,
        ST_DELAY = 3'd2,
        ST_INTEG = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t             r_state;
    logic               r_trig_a;
    logic               r_trig_b;
    logic        [7:0]  r_delay;
    logic        [7:0]  r_win;
    logic        [7:0]  r_cnt;
    logic signed [21:0] r_bl_acc;
    logic signed [25:0] r_acc;
    logic signed [15:0] r_baseline;
    logic signed [23:0] r_integ_out;
    logic signed [15:0] r_baseline_out;
    logic               r_out_valid;
    logic               r_oflow;
    logic               r_busy;

    logic               w_edge;
    logic signed [21:0] w_base_sum;
    logic signed [15:0] w_base_val;
    logic signed [16:0] w_diff;
    logic signed [25:0] w_integ_sum;
    logic        [24:0] w_sat;

    // Clamp a 26-bit accumulator into 24 bits; MSB of the result flags clamping.
    function automatic logic [24:0] sat24(input logic signed [25:0] a);
        logic [24:0] res;
        if (a > 26'sd8388607) begin
            res = {1'b1, 24'h7FFFFF};
        end else if (a < -26'sd8388608) begin
            res = {1'b1, 24'h800000};
        end else begin
            res = {1'b0, a[23:0]};
        end
        return res;
    endfunction

    // Datapath arithmetic shared by the FSM transitions.
    always_comb begin
        w_edge      = r_trig_a & ~r_trig_b;
        w_base_sum  = r_bl_acc + {{6{din[15]}}, din};
        w_base_val  = 16'(w_base_sum >>> LOG2_BL);
        w_diff      = {din[15], din} - {r_baseline[15], r_baseline};
        w_integ_sum = r_acc + {{9{w_diff[16]}}, w_diff};
        w_sat       = sat24(w_integ_sum);
    end

    // Trigger synchroniser, measurement FSM and registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_trig_a       <= 1'b0;
            r_trig_b       <= 1'b0;
            r_delay        <= 8'd0;
            r_win          <= 8'd0;
            r_cnt          <= 8'd0;
            r_bl_acc       <= 22'sd0;
            r_acc          <= 26'sd0;
            r_baseline     <= 16'sd0;
            r_integ_out    <= 24'sd0;
            r_baseline_out <= 16'sd0;
            r_out_valid    <= 1'b0;
            r_oflow        <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_trig_a    <= trig;
            r_trig_b    <= r_trig_a;
            r_out_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_edge) begin
                        r_delay  <= delay;
                        r_win    <= win_len;
                        r_cnt    <= 8'd0;
                        r_bl_acc <= 22'sd0;
                        r_acc    <= 26'sd0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_BASE;
                    end
                end
                ST_BASE: begin
                    r_bl_acc <= w_base_sum;
                    if (r_cnt == BL_LAST) begin
                        r_cnt      <= 8'd0;
                        r_baseline <= w_base_val;
                        if (r_delay != 8'd0) begin
                            r_state <= ST_DELAY;
                        end else if (r_win != 8'd0) begin
                            r_state <= ST_INTEG;
                        end else begin
                            r_state        <= ST_DONE;
                            r_out_valid    <= 1'b1;
                            r_integ_out    <= 24'sd0;
                            r_oflow        <= 1'b0;
                            r_baseline_out <= w_base_val;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_DELAY: begin
                    if (r_cnt == r_delay - 8'd1) begin
                        r_cnt <= 8'd0;
                        if (r_win != 8'd0) begin
                            r_state <= ST_INTEG;
                        end else begin
                            r_state        <= ST_DONE;
                            r_out_valid    <= 1'b1;
                            r_integ_out    <= 24'sd0;
                            r_oflow        <= 1'b0;
                            r_baseline_out <= r_baseline;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_INTEG: begin
                    r_acc <= w_integ_sum;
                    if (r_cnt == r_win - 8'd1) begin
                        r_cnt          <= 8'd0;
                        r_state        <= ST_DONE;
                        r_out_valid    <= 1'b1;
                        r_integ_out    <= w_sat[23:0];
                        r_oflow        <= w_sat[24];
                        r_baseline_out <= r_baseline;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign integ_out    = r_integ_out;
    assign baseline_out = r_baseline_out;
    assign out_valid    = r_out_valid;
    assign oflow        = r_oflow;
    assign busy         = r_busy;

endmodule

// File: tb/tb_trig_window_integrator.sv
// Randomised and directed bench for trig_window_integrator against a
// sample-index reference model (mean of baseline slice, sum of window slice).
module tb_trig_window_integrator;

    localparam int LOG2_BL = 4;
    localparam int BL      = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               trig;
    logic signed [15:0] din;
    logic        [7:0]  delay;
    logic        [7:0]  win_len;
    logic signed [23:0] integ_out;
    logic signed [15:0] baseline_out;
    logic               out_valid;
    logic               oflow;
    logic               busy;

    trig_window_integrator #(.LOG2_BL(LOG2_BL)) dut (
        .clk(clk), .rst(rst), .trig(trig), .din(din), .delay(delay),
        .win_len(win_len), .integ_out(integ_out), .baseline_out(baseline_out),
        .out_valid(out_valid), .oflow(oflow), .busy(busy)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int stim [0:599];

    // results of the most recent run
    int n_valid, got_k, got_integ, got_base, got_of, got_busy1;
    int snap_integ, snap_base, snap_of, snap_valid, snap_busy;

    // One trigger run: din[k] is applied for posedge P_k; xk = extra trigger pulse, rk = reset cycle.
    task automatic run(input int d, input int w, input int xk, input int rk);
        int last;
        last = 1 + BL + d + w + 6;
        n_valid = 0; got_k = -1; got_integ = 0; got_base = 0; got_of = 0; got_busy1 = 0;
        @(negedge clk); trig = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k <= last; k++) begin
            @(negedge clk);
            trig = (k < 2) || (k == xk) || (k == xk + 1);
            rst  = (k == rk);
            din  = 16'(stim[k]);
            if (k <= 1) begin
                delay = 8'(d); win_len = 8'(w);
            end else begin
                delay = 8'($urandom); win_len = 8'($urandom);
            end
            @(posedge clk); #1;
            if (k == 1) got_busy1 = int'(busy);
            if (k == rk) begin
                snap_integ = int'(integ_out); snap_base = int'(baseline_out);
                snap_of = int'(oflow); snap_valid = int'(out_valid); snap_busy = int'(busy);
            end
            if (out_valid) begin
                n_valid++;
                if (got_k < 0) begin
                    got_k = k; got_integ = int'(integ_out); got_base = int'(baseline_out); got_of = int'(oflow);
                end
            end
        end
        rst = 1'b0;
    endtask

    // Reference: floor-mean of samples P2..P(1+BL), clamped sum of (x - mean) over the window slice.
    task automatic model(input int d, input int w, output int e_integ, output int e_base, output int e_of);
        longint s, b, acc;
        s = 0; acc = 0;
        for (int k = 2; k <= 1 + BL; k++) s += stim[k];
        b = s / BL;
        if ((s % BL) != 0 && s < 0) b--;
        for (int k = 2 + BL + d; k <= 1 + BL + d + w; k++) acc += stim[k] - b;
        e_of = 0;
        if (acc > 8388607) begin acc = 8388607; e_of = 1; end
        if (acc < -8388608) begin acc = -8388608; e_of = 1; end
        e_integ = int'(acc); e_base = int'(b);
    endtask

    task automatic fill(input int v);
        for (int k = 0; k < 600; k++) stim[k] = v;
    endtask

    task automatic test_reset;
        rst = 1'b1; trig = 1'b0; din = 16'sd0; delay = 8'd0; win_len = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        if (integ_out !== 24'sd0) begin mismatched++; $display("FAIL reset_integ: got %0d want 0", integ_out); end
        compared++;
        if (baseline_out !== 16'sd0) begin mismatched++; $display("FAIL reset_base: got %0d want 0", baseline_out); end
        compared++;
        if (oflow !== 1'b0) begin mismatched++; $display("FAIL reset_oflow: got %0b want 0", oflow); end
        compared++;
        if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %0b want 0", busy); end
        compared++;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_held_trig;
        int cyc;
        cyc = -1;
        @(negedge clk); rst = 1'b1; trig = 1'b1; din = 16'sd55; delay = 8'd0; win_len = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(posedge clk);             // P0: edge seen
        @(posedge clk); #1;         // P1: accepted
        if (busy !== 1'b1) begin mismatched++; $display("FAIL held_trig_busy: got %0b want 1", busy); end
        compared++;
        for (int k = 2; k < 60 && cyc < 0; k++) begin
            @(posedge clk); #1;
            if (out_valid) cyc = k;
        end
        trig = 1'b0;
        if (cyc !== 17) begin mismatched++; $display("FAIL held_trig_timing: got %0d want 17", cyc); end
        compared++;
        if (baseline_out !== 16'sd55) begin mismatched++; $display("FAIL held_trig_base: got %0d want 55", baseline_out); end
        compared++;
    endtask

    task automatic test_constant;
        fill(100);
        run(4, 10, -1, -1);
        if (got_k !== 31) begin mismatched++; $display("FAIL const_timing: got %0d want 31", got_k); end
        compared++;
        if (got_integ !== 0) begin mismatched++; $display("FAIL const_integ: got %0d want 0", got_integ); end
        compared++;
        if (got_base !== 100) begin mismatched++; $display("FAIL const_base: got %0d want 100", got_base); end
        compared++;
        if (got_of !== 0) begin mismatched++; $display("FAIL const_oflow: got %0d want 0", got_of); end
        compared++;
        if (got_busy1 !== 1) begin mismatched++; $display("FAIL const_busy_p1: got %0d want 1", got_busy1); end
        compared++;
    endtask

    task automatic test_step;
        fill(1100);
        for (int k = 0; k <= 21; k++) stim[k] = 100;
        run(4, 10, -1, -1);
        if (got_integ !== 10000) begin mismatched++; $display("FAIL step_integ: got %0d want 10000", got_integ); end
        compared++;
        if (got_base !== 100) begin mismatched++; $display("FAIL step_base: got %0d want 100", got_base); end
        compared++;
    endtask

    task automatic test_saturate;
        fill(32767);
        for (int k = 0; k <= 1 + BL; k++) stim[k] = -32768;
        run(0, 255, -1, -1);
        if (got_integ !== 8388607) begin mismatched++; $display("FAIL sat_integ: got %0d want 8388607", got_integ); end
        compared++;
        if (got_of !== 1) begin mismatched++; $display("FAIL sat_oflow: got %0d want 1", got_of); end
        compared++;
        if (got_k !== 1 + BL + 255) begin mismatched++; $display("FAIL sat_timing: got %0d want %0d", got_k, 1 + BL + 255); end
        compared++;
        fill(-1234);
        run(2, 3, -1, -1);
        if (got_of !== 0) begin mismatched++; $display("FAIL sat_clear_oflow: got %0d want 0", got_of); end
        compared++;
        if (got_integ !== 0) begin mismatched++; $display("FAIL sat_clear_integ: got %0d want 0", got_integ); end
        compared++;
    endtask

    task automatic test_floor;
        fill(-4);
        for (int k = 2; k <= 1 + BL; k++) stim[k] = (k % 2 == 0) ? -3 : -4;
        run(3, 8, -1, -1);
        if (got_base !== -4) begin mismatched++; $display("FAIL floor_base: got %0d want -4", got_base); end
        compared++;
        if (got_integ !== 0) begin mismatched++; $display("FAIL floor_integ: got %0d want 0", got_integ); end
        compared++;
    endtask

    task automatic test_zero_window;
        fill(7);
        run(0, 0, -1, -1);
        if (got_k !== 17) begin mismatched++; $display("FAIL zero_win_timing: got %0d want 17", got_k); end
        compared++;
        if (got_integ !== 0) begin mismatched++; $display("FAIL zero_win_integ: got %0d want 0", got_integ); end
        compared++;
        if (got_base !== 7) begin mismatched++; $display("FAIL zero_win_base: got %0d want 7", got_base); end
        compared++;
    endtask

    task automatic test_ignored_trig;
        int ei, eb, eo;
        for (int k = 0; k < 600; k++) stim[k] = int'($urandom_range(0, 400)) - 200;
        model(2, 20, ei, eb, eo);
        run(2, 20, 2 + BL + 2 + 5, -1);
        if (n_valid !== 1) begin mismatched++; $display("FAIL ignored_trig_count: got %0d want 1", n_valid); end
        compared++;
        if (got_integ !== ei) begin mismatched++; $display("FAIL ignored_trig_integ: got %0d want %0d", got_integ, ei); end
        compared++;
    endtask

    task automatic test_abort;
        fill(300);
        run(3, 20, -1, 2 + BL + 3 + 4);
        if (n_valid !== 0) begin mismatched++; $display("FAIL abort_valid_count: got %0d want 0", n_valid); end
        compared++;
        if (snap_integ !== 0 || snap_base !== 0 || snap_of !== 0 || snap_valid !== 0) begin
            mismatched++;
            $display("FAIL abort_outputs: got integ=%0d base=%0d oflow=%0d valid=%0d want all 0",
                     snap_integ, snap_base, snap_of, snap_valid);
        end
        compared++;
        if (snap_busy !== 0) begin mismatched++; $display("FAIL abort_busy: got %0d want 0", snap_busy); end
        compared++;
        fill(-50);
        for (int k = 2 + BL + 1; k < 600; k++) stim[k] = -40;
        run(1, 6, -1, -1);
        if (got_integ !== 60 || got_base !== -50) begin
            mismatched++; $display("FAIL abort_recover: got integ=%0d base=%0d want 60 -50", got_integ, got_base);
        end
        compared++;
    endtask

    task automatic test_random;
        int d, w, ei, eb, eo, span;
        for (int it = 0; it < 16; it++) begin
            d    = (it % 4 == 0) ? 0 : int'($urandom_range(1, 20));
            w    = (it % 5 == 0) ? int'($urandom_range(200, 255)) : int'($urandom_range(0, 40));
            span = (it % 3 == 0) ? 32767 : int'($urandom_range(1, 2000));
            for (int k = 0; k < 600; k++) stim[k] = int'($urandom_range(0, 2 * span)) - span;
            if (it % 5 == 0) for (int k = 2 + BL + d; k < 600; k++) stim[k] = (it % 2 == 0) ? 32000 : -32000;
            model(d, w, ei, eb, eo);
            run(d, w, -1, -1);
            if (got_k !== 1 + BL + d + w || n_valid !== 1) begin
                mismatched++; $display("FAIL rand%0d_timing: got k=%0d n=%0d want k=%0d n=1", it, got_k, n_valid, 1 + BL + d + w);
            end
            compared++;
            if (got_integ !== ei || got_base !== eb || got_of !== eo) begin
                mismatched++;
                $display("FAIL rand%0d_result: got integ=%0d base=%0d oflow=%0d want %0d %0d %0d",
                         it, got_integ, got_base, got_of, ei, eb, eo);
            end
            compared++;
        end
    endtask

    initial begin
        rst = 1'b1; trig = 1'b0; din = 16'sd0; delay = 8'd0; win_len = 8'd0;
        test_reset;
        test_held_trig;
        test_constant;
        test_step;
        test_saturate;
        test_floor;
        test_zero_window;
        test_ignored_trig;
        test_abort;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
